// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: finds P0/Pr sync, tracks bit position 0..99 and
// emits one-cycle BCD strobes that steer a downstream bcd_accumulator.
module irig_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_symbol_valid,
  input  logic [1:0] i_symbol,
  output logic       o_bcd_bit,
  output logic [2:0] o_bcd_bit_idx,
  output logic [1:0] o_bcd_digit_idx,
  output logic [4:0] o_ts_select,
  output logic       o_accum_rst,
  output logic       o_ts_valid,
  output logic       o_locked,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SYM_ZERO   = 2'b00;
  localparam logic [1:0] SYM_ONE    = 2'b01;
  localparam logic [1:0] SYM_MARKER = 2'b10;
  localparam logic [1:0] SYM_ERROR  = 2'b11;

  localparam logic [4:0] SEL_SEC  = 5'b00001;
  localparam logic [4:0] SEL_MIN  = 5'b00010;
  localparam logic [4:0] SEL_HOUR = 5'b00100;
  localparam logic [4:0] SEL_DAY  = 5'b01000;
  localparam logic [4:0] SEL_YEAR = 5'b10000;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC1 = 2'd1,
    FRAME = 2'd2
  } StateT;

  StateT           r_state;
  logic [6:0]      r_bitPos;
  logic [TW-1:0]   r_timeout;
  logic            r_bcdBit;
  logic [2:0]      r_bitIdx;
  logic [1:0]      r_digitIdx;
  logic [4:0]      r_tsSel;
  logic            r_accumRst;
  logic            r_tsValid;
  logic            r_frameErr;

  StateT           w_stateNext;
  logic [6:0]      w_bitPosNext;
  logic [TW-1:0]   w_timeoutNext;
  logic            w_bcdBitNext;
  logic [2:0]      w_bitIdxNext;
  logic [1:0]      w_digitIdxNext;
  logic [4:0]      w_tsSelNext;
  logic            w_accumRstNext;
  logic            w_tsValidNext;
  logic            w_frameErrNext;

  logic [6:0]      w_nextPos;
  logic            w_isMarkPos;
  logic            w_isMarker;
  logic            w_expire;
  logic [4:0]      w_mapSel;
  logic [1:0]      w_mapDigit;
  logic [2:0]      w_mapIdx;

  // Position the incoming symbol would occupy inside the frame, and whether
  // that slot must carry a position marker (9, 19, ..., 99).
  assign w_nextPos   = r_bitPos + 7'd1;
  assign w_isMarkPos = ((w_nextPos % 7'd10) == 7'd9);
  assign w_isMarker  = (i_symbol == SYM_MARKER);
  assign w_expire    = !i_symbol_valid && (r_timeout == TIMEOUT_LAST);

  // Translate frame position into timestamp field, digit and bit weight.
  always_comb begin
    w_mapSel   = '0;
    w_mapDigit = '0;
    w_mapIdx   = '0;
    case (w_nextPos) inside
      [7'd1:7'd4]:   begin w_mapSel = SEL_SEC;  w_mapDigit = 2'd0; w_mapIdx = 3'(w_nextPos - 7'd1);  end
      [7'd6:7'd8]:   begin w_mapSel = SEL_SEC;  w_mapDigit = 2'd1; w_mapIdx = 3'(w_nextPos - 7'd6);  end
      [7'd10:7'd13]: begin w_mapSel = SEL_MIN;  w_mapDigit = 2'd0; w_mapIdx = 3'(w_nextPos - 7'd10); end
      [7'd15:7'd17]: begin w_mapSel = SEL_MIN;  w_mapDigit = 2'd1; w_mapIdx = 3'(w_nextPos - 7'd15); end
      [7'd20:7'd23]: begin w_mapSel = SEL_HOUR; w_mapDigit = 2'd0; w_mapIdx = 3'(w_nextPos - 7'd20); end
      [7'd25:7'd26]: begin w_mapSel = SEL_HOUR; w_mapDigit = 2'd1; w_mapIdx = 3'(w_nextPos - 7'd25); end
      [7'd30:7'd33]: begin w_mapSel = SEL_DAY;  w_mapDigit = 2'd0; w_mapIdx = 3'(w_nextPos - 7'd30); end
      [7'd35:7'd38]: begin w_mapSel = SEL_DAY;  w_mapDigit = 2'd1; w_mapIdx = 3'(w_nextPos - 7'd35); end
      [7'd40:7'd41]: begin w_mapSel = SEL_DAY;  w_mapDigit = 2'd2; w_mapIdx = 3'(w_nextPos - 7'd40); end
      [7'd50:7'd53]: begin w_mapSel = SEL_YEAR; w_mapDigit = 2'd0; w_mapIdx = 3'(w_nextPos - 7'd50); end
      [7'd55:7'd58]: begin w_mapSel = SEL_YEAR; w_mapDigit = 2'd1; w_mapIdx = 3'(w_nextPos - 7'd55); end
      default: ;
    endcase
  end

  // Next-state and next-output logic; pulses default low, BCD data holds.
  always_comb begin
    w_stateNext    = r_state;
    w_bitPosNext   = r_bitPos;
    w_timeoutNext  = r_timeout;
    w_bcdBitNext   = r_bcdBit;
    w_bitIdxNext   = r_bitIdx;
    w_digitIdxNext = r_digitIdx;
    w_tsSelNext    = '0;
    w_accumRstNext = 1'b0;
    w_tsValidNext  = 1'b0;
    w_frameErrNext = 1'b0;

    case (r_state)
      HUNT: begin
        w_timeoutNext = '0;
        w_bitPosNext  = '0;
        if (i_symbol_valid && w_isMarker) begin
          w_stateNext = SYNC1;
        end
      end

      SYNC1: begin
        if (i_symbol_valid) begin
          w_timeoutNext = '0;
          if (w_isMarker) begin
            w_stateNext    = FRAME;
            w_bitPosNext   = '0;
            w_accumRstNext = 1'b1;
          end else begin
            w_stateNext = HUNT;
          end
        end else if (w_expire) begin
          w_stateNext    = HUNT;
          w_frameErrNext = 1'b1;
        end else begin
          w_timeoutNext = r_timeout + TW'(1);
        end
      end

      FRAME: begin
        if (i_symbol_valid) begin
          w_timeoutNext = '0;
          if (i_symbol == SYM_ERROR) begin
            w_stateNext    = HUNT;
            w_frameErrNext = 1'b1;
          end else if (r_bitPos == 7'd99) begin
            // Symbol after P0 must be the reference marker Pr.
            if (w_isMarker) begin
              w_bitPosNext   = '0;
              w_accumRstNext = 1'b1;
            end else begin
              w_stateNext    = HUNT;
              w_frameErrNext = 1'b1;
            end
          end else if (w_isMarker != w_isMarkPos) begin
            w_stateNext    = HUNT;
            w_frameErrNext = 1'b1;
          end else begin
            w_bitPosNext = w_nextPos;
            if (w_isMarker && (w_nextPos == 7'd99)) begin
              w_tsValidNext = 1'b1;
            end else if (w_mapSel != 5'b00000) begin
              w_tsSelNext    = w_mapSel;
              w_digitIdxNext = w_mapDigit;
              w_bitIdxNext   = w_mapIdx;
              w_bcdBitNext   = (i_symbol == SYM_ONE);
            end
          end
        end else if (w_expire) begin
          w_stateNext    = HUNT;
          w_frameErrNext = 1'b1;
        end else begin
          w_timeoutNext = r_timeout + TW'(1);
        end
      end

      default: begin
        w_stateNext = HUNT;
      end
    endcase
  end

  // State, position, timeout and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= HUNT;
      r_bitPos   <= '0;
      r_timeout  <= '0;
      r_bcdBit   <= 1'b0;
      r_bitIdx   <= '0;
      r_digitIdx <= '0;
      r_tsSel    <= '0;
      r_accumRst <= 1'b0;
      r_tsValid  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_bitPos   <= w_bitPosNext;
      r_timeout  <= w_timeoutNext;
      r_bcdBit   <= w_bcdBitNext;
      r_bitIdx   <= w_bitIdxNext;
      r_digitIdx <= w_digitIdxNext;
      r_tsSel    <= w_tsSelNext;
      r_accumRst <= w_accumRstNext;
      r_tsValid  <= w_tsValidNext;
      r_frameErr <= w_frameErrNext;
    end
  end

  assign o_bcd_bit       = r_bcdBit;
  assign o_bcd_bit_idx   = r_bitIdx;
  assign o_bcd_digit_idx = r_digitIdx;
  assign o_ts_select     = r_tsSel;
  assign o_accum_rst     = r_accumRst;
  assign o_ts_valid      = r_tsValid;
  assign o_locked        = (r_state == FRAME);
  assign o_frame_err     = r_frameErr;

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Directed bench for irig_frame_sequencer: sync, full frames, sync loss,
// timeout and asynchronous reset, with a small accumulator model.
module tb_irig_frame_sequencer;

  localparam logic [1:0] S_ZERO = 2'b00;
  localparam logic [1:0] S_ONE  = 2'b01;
  localparam logic [1:0] S_MARK = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_symbol_valid;
  logic [1:0] i_symbol;
  logic       o_bcd_bit;
  logic [2:0] o_bcd_bit_idx;
  logic [1:0] o_bcd_digit_idx;
  logic [4:0] o_ts_select;
  logic       o_accum_rst;
  logic       o_ts_valid;
  logic       o_locked;
  logic       o_frame_err;

  int nChecks = 0;
  int nPass   = 0;
  int strobeCount;
  int tsValidCount;
  int accSec, accMin, accHour, accDay, accYear;

  // Timestamp field layout: start position, length, select, digit, value
  // for 12:34:56, day 123, year 24.
  int         fBase[11]  = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
  int         fLen[11]   = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};
  int         fDigit[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 1};
  int         fVal[11]   = '{6, 5, 4, 3, 2, 1, 3, 2, 1, 4, 2};
  logic [4:0] fSel[11]   = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100,
                             5'b01000, 5'b01000, 5'b01000, 5'b10000, 5'b10000};
  logic [1:0] frameSym[100];

  irig_frame_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_symbol_valid  (i_symbol_valid),
    .i_symbol        (i_symbol),
    .o_bcd_bit       (o_bcd_bit),
    .o_bcd_bit_idx   (o_bcd_bit_idx),
    .o_bcd_digit_idx (o_bcd_digit_idx),
    .o_ts_select     (o_ts_select),
    .o_accum_rst     (o_accum_rst),
    .o_ts_valid      (o_ts_valid),
    .o_locked        (o_locked),
    .o_frame_err     (o_frame_err)
  );

  // 10 ns clock.
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One symbol_valid cycle; returns on the falling edge after the DUT responded.
  task automatic applyStimulus(input logic [1:0] sym);
    @(negedge i_clk);
    i_symbol_valid = 1'b1;
    i_symbol       = sym;
    @(negedge i_clk);
    i_symbol_valid = 1'b0;
    i_symbol       = S_ZERO;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  function automatic void expMap(input int pos, output logic [4:0] sel, output logic [1:0] dig,
                                 output logic [2:0] idx);
    sel = '0;
    dig = '0;
    idx = '0;
    for (int f = 0; f < 11; f++) begin
      if (pos >= fBase[f] && pos < fBase[f] + fLen[f]) begin
        sel = fSel[f];
        dig = 2'(fDigit[f]);
        idx = 3'(pos - fBase[f]);
      end
    end
  endfunction

  // Sends frame positions fromPos..toPos and checks every response.
  task automatic runFrame(input int fromPos, input int toPos);
    logic [4:0] eSel;
    logic [1:0] eDig;
    logic [2:0] eIdx;
    int         weight;
    for (int pos = fromPos; pos <= toPos; pos++) begin
      applyStimulus(frameSym[pos]);
      expMap(pos, eSel, eDig, eIdx);
      checkOutput($sformatf("ts_select@%0d", pos), 32'(o_ts_select), 32'(eSel));
      checkOutput($sformatf("ts_valid@%0d", pos), 32'(o_ts_valid), 32'(pos == 99));
      checkOutput($sformatf("frame_err@%0d", pos), 32'(o_frame_err), 32'd0);
      checkOutput($sformatf("locked@%0d", pos), 32'(o_locked), 32'd1);
      if (eSel != 5'b00000) begin
        checkOutput($sformatf("digit@%0d", pos), 32'(o_bcd_digit_idx), 32'(eDig));
        checkOutput($sformatf("bitidx@%0d", pos), 32'(o_bcd_bit_idx), 32'(eIdx));
        checkOutput($sformatf("bit@%0d", pos), 32'(o_bcd_bit), 32'(frameSym[pos] == S_ONE));
      end
      if (o_ts_select != 5'b00000) begin
        strobeCount++;
        weight = (o_bcd_digit_idx == 2'd0) ? 1 : (o_bcd_digit_idx == 2'd1) ? 10 : 100;
        weight = o_bcd_bit ? weight * (1 << o_bcd_bit_idx) : 0;
        case (o_ts_select)
          5'b00001: accSec  += weight;
          5'b00010: accMin  += weight;
          5'b00100: accHour += weight;
          5'b01000: accDay  += weight;
          5'b10000: accYear += weight;
          default: ;
        endcase
      end
      if (o_ts_valid) tsValidCount++;
    end
  endtask

  task automatic clearAccum();
    accSec = 0; accMin = 0; accHour = 0; accDay = 0; accYear = 0;
    strobeCount = 0;
  endtask

  task automatic relock(input string tag);
    applyStimulus(S_MARK);
    checkOutput({tag, "_m1_locked"}, 32'(o_locked), 32'd0);
    checkOutput({tag, "_m1_accum"}, 32'(o_accum_rst), 32'd0);
    applyStimulus(S_MARK);
    checkOutput({tag, "_m2_accum"}, 32'(o_accum_rst), 32'd1);
    checkOutput({tag, "_m2_locked"}, 32'(o_locked), 32'd1);
  endtask

  initial begin
    for (int p = 0; p < 100; p++) frameSym[p] = ((p % 10) == 9 || p == 0) ? S_MARK : S_ZERO;
    for (int f = 0; f < 11; f++)
      for (int i = 0; i < fLen[f]; i++)
        frameSym[fBase[f] + i] = ((fVal[f] >> i) & 1) != 0 ? S_ONE : S_ZERO;

    i_rst_n        = 1'b0;
    i_symbol_valid = 1'b0;
    i_symbol       = S_ZERO;
    idleCycles(3);
    checkOutput("rst_ts_select", 32'(o_ts_select), 32'd0);
    checkOutput("rst_accum", 32'(o_accum_rst), 32'd0);
    checkOutput("rst_ts_valid", 32'(o_ts_valid), 32'd0);
    checkOutput("rst_locked", 32'(o_locked), 32'd0);
    checkOutput("rst_frame_err", 32'(o_frame_err), 32'd0);
    checkOutput("rst_bit", 32'(o_bcd_bit), 32'd0);
    checkOutput("rst_bitidx", 32'(o_bcd_bit_idx), 32'd0);
    checkOutput("rst_digit", 32'(o_bcd_digit_idx), 32'd0);
    i_rst_n = 1'b1;

    $display("[TB] sync and first frame");
    applyStimulus(S_ONE);
    checkOutput("hunt_one_locked", 32'(o_locked), 32'd0);
    checkOutput("hunt_one_sel", 32'(o_ts_select), 32'd0);
    relock("sync");
    clearAccum();
    tsValidCount = 0;
    runFrame(1, 99);
    checkOutput("f1_strobes", 32'(strobeCount), 32'd38);
    checkOutput("f1_sec", 32'(accSec), 32'd56);
    checkOutput("f1_min", 32'(accMin), 32'd34);
    checkOutput("f1_hour", 32'(accHour), 32'd12);
    checkOutput("f1_day", 32'(accDay), 32'd123);
    checkOutput("f1_year", 32'(accYear), 32'd24);
    idleCycles(1);
    checkOutput("f1_ts_valid_drop", 32'(o_ts_valid), 32'd0);
    checkOutput("f1_locked_hold", 32'(o_locked), 32'd1);

    $display("[TB] back-to-back frame");
    applyStimulus(S_MARK);
    checkOutput("pr1_accum", 32'(o_accum_rst), 32'd1);
    checkOutput("pr1_locked", 32'(o_locked), 32'd1);
    checkOutput("pr1_frame_err", 32'(o_frame_err), 32'd0);
    clearAccum();
    runFrame(1, 99);
    checkOutput("f2_strobes", 32'(strobeCount), 32'd38);
    checkOutput("f2_ts_valid_count", 32'(tsValidCount), 32'd2);
    applyStimulus(S_MARK);
    checkOutput("pr2_accum", 32'(o_accum_rst), 32'd1);
    checkOutput("pr2_locked", 32'(o_locked), 32'd1);

    $display("[TB] marker at position 15");
    runFrame(1, 14);
    applyStimulus(S_MARK);
    checkOutput("m15_frame_err", 32'(o_frame_err), 32'd1);
    checkOutput("m15_locked", 32'(o_locked), 32'd0);
    checkOutput("m15_sel", 32'(o_ts_select), 32'd0);
    checkOutput("m15_ts_valid", 32'(o_ts_valid), 32'd0);
    idleCycles(1);
    checkOutput("m15_err_drop", 32'(o_frame_err), 32'd0);
    applyStimulus(S_ONE);
    checkOutput("m15_after_sel", 32'(o_ts_select), 32'd0);
    checkOutput("m15_after_err", 32'(o_frame_err), 32'd0);
    applyStimulus(S_ZERO);
    checkOutput("m15_after2_sel", 32'(o_ts_select), 32'd0);
    relock("m15");

    $display("[TB] missing marker at position 29");
    runFrame(1, 28);
    applyStimulus(S_ZERO);
    checkOutput("p29_frame_err", 32'(o_frame_err), 32'd1);
    checkOutput("p29_locked", 32'(o_locked), 32'd0);
    relock("p29");

    $display("[TB] error symbol mid-frame");
    runFrame(1, 5);
    applyStimulus(S_ERR);
    checkOutput("err_frame_err", 32'(o_frame_err), 32'd1);
    checkOutput("err_locked", 32'(o_locked), 32'd0);
    checkOutput("err_sel", 32'(o_ts_select), 32'd0);
    relock("err");

    $display("[TB] timeout expiry");
    idleCycles(49);
    checkOutput("to49_frame_err", 32'(o_frame_err), 32'd0);
    checkOutput("to49_locked", 32'(o_locked), 32'd1);
    idleCycles(1);
    checkOutput("to50_frame_err", 32'(o_frame_err), 32'd1);
    checkOutput("to50_locked", 32'(o_locked), 32'd0);
    idleCycles(1);
    checkOutput("to51_err_drop", 32'(o_frame_err), 32'd0);
    relock("to");
    idleCycles(48);
    applyStimulus(S_ZERO);
    checkOutput("to_sym50_frame_err", 32'(o_frame_err), 32'd0);
    checkOutput("to_sym50_locked", 32'(o_locked), 32'd1);
    checkOutput("to_sym50_sel", 32'(o_ts_select), 32'd1);

    $display("[TB] asynchronous reset at position 33");
    runFrame(2, 33);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_sel", 32'(o_ts_select), 32'd0);
    checkOutput("arst_locked", 32'(o_locked), 32'd0);
    checkOutput("arst_bitidx", 32'(o_bcd_bit_idx), 32'd0);
    checkOutput("arst_frame_err", 32'(o_frame_err), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(S_ZERO);
    checkOutput("arst_zero_sel", 32'(o_ts_select), 32'd0);
    checkOutput("arst_zero_locked", 32'(o_locked), 32'd0);
    checkOutput("arst_zero_err", 32'(o_frame_err), 32'd0);
    relock("arst");
    applyStimulus(S_ONE);
    checkOutput("arst_p1_sel", 32'(o_ts_select), 32'd1);
    checkOutput("arst_p1_bit", 32'(o_bcd_bit), 32'd1);
    checkOutput("arst_p1_idx", 32'(o_bcd_bit_idx), 32'd0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
